delay_seq_gen: RTL and testbench
================================

// Module: delay_seq_gen
// PURPOSE
//   Stimulus-side generator for the a-then-b delay protocol: on an accepted request it drives
//   a pulse on a, then b exactly N cycles later (a ##N b). Used as the driving end in delay-
//   operator benches and formal harnesses, producing the sequences that the cover checks observe.
//   One transaction in flight; request/ready handshake on the input side.
// PARAMETERS
//   MAX_DELAY  15   largest legal delay in cycles; req_delay values above it are clamped
//   DELAY_W    4    width of req_delay; must satisfy 2**DELAY_W > MAX_DELAY
// PORTS
//   clk        in   1        single clock; all logic on posedge
//   rst        in   1        synchronous, active-high reset
//   req_valid  in   1        request to emit one a ##N b sequence
//   req_ready  out  1        generator can accept a request (high only in IDLE)
//   req_delay  in   DELAY_W  N, sampled on acceptance; ignored otherwise
//   a          out  1        first event of the sequence
//   b          out  1        second event, N cycles after the first a
//   busy       out  1        transaction in flight (state != IDLE)
//   done       out  1        one-cycle pulse, coincident with b
// BEHAVIOUR
//   - Reset: rst sampled high at edge -> next cycle a=b=done=busy=req_ready=0, state=IDLE,
//     counter=0. req_valid during rst is ignored. req_ready rises in first cycle after rst low.
//   - a is never high in the first cycle after reset; every a-assertion starts a fresh sequence.
//   - Accept: req_valid && req_ready sampled at edge T. N = min(req_delay, MAX_DELAY) latched.
//   - FSM states IDLE, EMIT_A, WAIT, EMIT_B, EMIT_AB:
//       IDLE    -> EMIT_AB if accepted and N==0; -> EMIT_A if accepted and N>=1
//       EMIT_A  (a=1)    -> EMIT_B if N==1; else WAIT with cnt=N-2
//       WAIT    -> EMIT_B when cnt==0, else cnt-=1
//       EMIT_B  (b=1, done=1)       -> IDLE
//       EMIT_AB (a=1, b=1, done=1)  -> IDLE
//   - Timing: a high in cycle T+1. b high in cycle T+1+N. done=b.
//     Examples: N=1 -> a@T+1, b@T+2. N=3 -> a@T+1, b@T+4.
//   - req_ready=0 from T+1 through the b cycle inclusive. It is 1 in the cycle after b, so the
//     fastest back-to-back spacing is b@k, next accept@k+1, next a@k+2.
//   - busy=1 exactly while the FSM is not in IDLE.
//   - Counter is DELAY_W wide and never wraps: it is loaded only with N-2 >= 0 and decremented
//     only while nonzero.
//   - Reset mid-sequence: all outputs drop at the next edge. No b or done is emitted for the
//     aborted transaction.
//   - a and b are registered outputs (Moore, decoded from the state register); no input-to-
//     output combinational path except req_ready, which is decoded from state only.
// CONFIGURATION
//   DSG_A_HOLD_EN defined:
//     a is held high continuously from EMIT_A through EMIT_B inclusive, i.e. N+1 cycles.
//     Every rise of a is followed by a high on the next cycle whenever N>=1.
//   DSG_A_HOLD_EN undefined:
//     a is a single-cycle pulse in EMIT_A only.
//   N==0 (EMIT_AB) behaves identically in both builds. b, done, busy and req_ready are unaffected.
// STRUCTURE
//   Package delay_seq_pkg:
//     - state enum delay_seq_state_e {IDLE, EMIT_A, WAIT, EMIT_B, EMIT_AB}
//     - function clamp_delay(raw, max)
//   Sub-module delay_seq_cnt: loadable DELAY_W down-counter with load/dec/zero flag.
//   FSM and output decode stay in delay_seq_gen.
// TESTING
//   1. rst held 3 cycles with req_valid=1 -> a=b=done=busy=req_ready=0 throughout;
//      req_ready=1 on the first cycle after rst falls.
//   2. Accept N=1 at T -> a@T+1, b=done@T+2, req_ready=1@T+3, busy high T+1..T+2 only.
//   3. Accept N=3 at T -> a@T+1, b@T+4. Build with DSG_A_HOLD_EN -> a high T+1..T+4;
//      build without it -> a high at T+1 only.
//   4. Accept N=0 -> a and b both high in the same single cycle T+1, done pulses once.
//   5. req_delay=15 then req_delay held at 5 with req_valid=1 continuously -> b@T+16,
//      second accept @T+17, second b @T+23. Also req_delay above MAX_DELAY (build MAX_DELAY=7)
//      -> treated as 7.
//   6. Accept N=6, assert rst in the WAIT state -> no b and no done ever appear;
//      a new request after reset completes normally.

Source files
------------

// File: rtl/delay_seq_pkg.sv
// Shared types and helpers for the a ##N b delay-sequence generator.
package delay_seq_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    EMIT_A  = 3'd1,
    WAIT    = 3'd2,
    EMIT_B  = 3'd3,
    EMIT_AB = 3'd4
  } delay_seq_state_e;

  function automatic int unsigned clamp_delay(input int unsigned raw,
                                              input int unsigned max_delay);
    return (raw > max_delay) ? max_delay : raw;
  endfunction

endpackage

// File: rtl/delay_seq_cnt.sv
// Loadable down-counter; decrements only while nonzero so it can never wrap.
module delay_seq_cnt #(
  parameter int unsigned DELAY_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DELAY_W-1:0] load_val,
  input  logic               dec,
  output logic               zero
);

  logic [DELAY_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - DELAY_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/delay_seq_gen.sv
// a ##N b stimulus generator with req/ready handshake, one transaction in flight.
// Define DSG_A_HOLD_EN to hold a high from EMIT_A through EMIT_B instead of pulsing it.
module delay_seq_gen
  import delay_seq_pkg::*;
#(
  parameter int unsigned MAX_DELAY = 15,
  parameter int unsigned DELAY_W   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [DELAY_W-1:0] req_delay,
  output logic               a,
  output logic               b,
  output logic               busy,
  output logic               done
);

  delay_seq_state_e   state_q, state_d;
  logic [DELAY_W-1:0] n_q, n_d;
  logic [DELAY_W-1:0] n_clamped;
  logic [DELAY_W-1:0] cnt_load_val;
  logic               init_q;
  logic               accept;
  logic               cnt_load;
  logic               cnt_dec;
  logic               cnt_zero;

  assign n_clamped = DELAY_W'(clamp_delay(32'(req_delay), MAX_DELAY));

  // init_q keeps req_ready low through the reset cycles themselves.
  assign req_ready = init_q && (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    cnt_load     = 1'b0;
    cnt_dec      = 1'b0;
    cnt_load_val = n_q - DELAY_W'(2);
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          n_d     = n_clamped;
          state_d = (n_clamped == '0) ? EMIT_AB : EMIT_A;
        end
      end
      EMIT_A: begin
        if (n_q == DELAY_W'(1)) begin
          state_d = EMIT_B;
        end else begin
          state_d  = WAIT;
          cnt_load = 1'b1;
        end
      end
      WAIT: begin
        if (cnt_zero) begin
          state_d = EMIT_B;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      EMIT_B, EMIT_AB: state_d = IDLE;
      default:         state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      n_q     <= '0;
      init_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      init_q  <= 1'b1;
    end
  end

  delay_seq_cnt #(
    .DELAY_W(DELAY_W)
  ) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .dec      (cnt_dec),
    .zero     (cnt_zero)
  );

`ifdef DSG_A_HOLD_EN
  assign a = (state_q == EMIT_A) || (state_q == WAIT) || (state_q == EMIT_B) ||
             (state_q == EMIT_AB);
`else
  assign a = (state_q == EMIT_A) || (state_q == EMIT_AB);
`endif
  assign b    = (state_q == EMIT_B) || (state_q == EMIT_AB);
  assign done = b;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_delay_seq_gen.sv
// Self-checking bench for delay_seq_gen; per-cycle expected outputs are queued and compared.
module tb_delay_seq_gen;

`ifdef DSG_A_HOLD_EN
  localparam bit Hold = 1'b1;
`else
  localparam bit Hold = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rv  = 1'b0;
  logic       sel = 1'b0;
  logic [3:0] rd  = 4'd0;

  logic rv0, rv7;
  logic ready0, a0, b0, busy0, done0;
  logic ready7, a7, b7, busy7, done7;
  logic [4:0] obs;

  int n_checks = 0;
  int n_fail   = 0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  assign rv0 = rv & ~sel;
  assign rv7 = rv & sel;
  assign obs = sel ? {a7, b7, done7, busy7, ready7} : {a0, b0, done0, busy0, ready0};

  delay_seq_gen #(
    .MAX_DELAY(15),
    .DELAY_W  (4)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (rv0),
    .req_ready (ready0),
    .req_delay (rd),
    .a         (a0),
    .b         (b0),
    .busy      (busy0),
    .done      (done0)
  );

  delay_seq_gen #(
    .MAX_DELAY(7),
    .DELAY_W  (4)
  ) u_dut7 (
    .clk       (clk),
    .rst       (rst),
    .req_valid (rv7),
    .req_ready (ready7),
    .req_delay (rd),
    .a         (a7),
    .b         (b7),
    .busy      (busy7),
    .done      (done7)
  );

  // Expected {a,b,done,busy,ready} for cycles T+1 .. T+N+2 of one transaction accepted at T.
  function automatic void push_txn(input int d);
    int maxd;
    int n;
    logic ea;
    logic eb;
    maxd = sel ? 7 : 15;
    n    = (d > maxd) ? maxd : d;
    for (int k = 1; k <= n + 1; k++) begin
      ea = Hold || (k == 1);
      eb = (k == n + 1);
      exp_q.push_back({ea, eb, eb, 1'b1, 1'b0});
    end
    exp_q.push_back(5'b00001);
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    rv  = 1'b1;
    rd  = 4'd3;
    repeat (3) exp_q.push_back(5'b00000);
    exp_q.push_back(5'b00001);
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [4:0] e;
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset cycle %0d: {a,b,done,busy,ready} got %b expected %b", i, obs, e);
      end
      if (i == 2) begin
        rst = 1'b0;
        rv  = 1'b0;
      end
    end
  endtask

  task automatic test_single_delay(input int d);
    rv = 1'b1;
    rd = 4'(d);
    push_txn(d);
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [4:0] e;
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL delay%0d cycle T+%0d: {a,b,done,busy,ready} got %b expected %b",
                 d, i + 1, obs, e);
      end
      if (i == 0) begin
        rv = 1'b0;
        rd = 4'($urandom_range(0, 15));
      end
    end
  endtask

  task automatic test_back_to_back();
    rv = 1'b1;
    rd = 4'd15;
    push_txn(15);
    push_txn(5);
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [4:0] e;
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL back_to_back cycle T+%0d: {a,b,done,busy,ready} got %b expected %b",
                 i + 1, obs, e);
      end
      if (i == 0) rd = 4'd5;
      if (i == 17) rv = 1'b0;
    end
  endtask

  task automatic test_clamp();
    sel = 1'b1;
    rv  = 1'b1;
    rd  = 4'd12;
    push_txn(12);
    push_txn(7);
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [4:0] e;
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL clamp cycle T+%0d: {a,b,done,busy,ready} got %b expected %b",
                 i + 1, obs, e);
      end
      if (i == 0) rv = 1'b0;
      if (i == 8) begin
        rv = 1'b1;
        rd = 4'd7;
      end
      if (i == 9) rv = 1'b0;
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid();
    rv = 1'b1;
    rd = 4'd6;
    exp_q.push_back(5'b10010);
    repeat (2) exp_q.push_back({Hold, 4'b0010});
    repeat (2) exp_q.push_back(5'b00000);
    repeat (6) exp_q.push_back(5'b00001);
    push_txn(2);
    for (int i = 0; exp_q.size() > 0; i++) begin
      logic [4:0] e;
      @(negedge clk);
      e = exp_q.pop_front();
      n_checks++;
      if (obs !== e) begin
        n_fail++;
        $display("FAIL reset_mid cycle %0d: {a,b,done,busy,ready} got %b expected %b",
                 i, obs, e);
      end
      if (i == 0) rv = 1'b0;
      if (i == 2) rst = 1'b1;
      if (i == 4) rst = 1'b0;
      if (i == 10) begin
        rv = 1'b1;
        rd = 4'd2;
      end
      if (i == 11) rv = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_delay(1);
    test_single_delay(3);
    test_single_delay(0);
    test_single_delay(2);
    test_back_to_back();
    test_clamp();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
